// File: rtl/cart_pkg.sv
// Shared constants, slot field layout and FSM state encoding for the cart register.
package cart_pkg;
  localparam int N_SLOTS      = 6;
  localparam int ID_W         = 8;
  localparam int PRICE_DIGITS = 4;
  localparam int TOTAL_DIGITS = 5;
  localparam int PRICE_W      = 4 * PRICE_DIGITS;
  localparam int TOTAL_W      = 4 * TOTAL_DIGITS;
  localparam int QTY_W        = 8;
  localparam int IDX_W        = $clog2(N_SLOTS);

  localparam int SLOT_W   = 40;
  localparam int QTY_LSB  = 32;
  localparam int UNIT_LSB = 16;
  localparam int LINE_LSB = 0;

  localparam logic [ID_W-1:0] EMPTY_ID = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_CHECK,
    ST_COMMIT
  } state_e;
endpackage

// File: rtl/bcd_adder.sv
// Combinational packed-BCD adder: per-digit sum with decimal carry, carry out of the top digit.
module bcd_adder #(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] a_i,
  input  logic [4*DIGITS-1:0] b_i,
  output logic [4*DIGITS-1:0] sum_o,
  output logic                carry_o
);

  always_comb begin
    logic [4:0] digit;
    logic       carry;
    carry = 1'b0;
    digit = '0;
    sum_o = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = {1'b0, a_i[4*i +: 4]} + {1'b0, b_i[4*i +: 4]} + {4'b0, carry};
      carry = (digit > 5'd9);
      if (carry) digit = digit + 5'd6;
      sum_o[4*i +: 4] = digit[3:0];
    end
    carry_o = carry;
  end

endmodule

// File: rtl/cart_accumulator.sv
// Six-slot shopping cart register feeding the display buses; one scan takes a fixed 8 cycles.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for a scan; ID 0x00 is rejected here without a stall
// ST_SCAN   | walk slots 0..5, note first ID hit and lowest empty slot
// ST_CHECK  | form candidate qty/line/total and the reject decision
// ST_COMMIT | write slot and total, or pulse err and keep state
module cart_accumulator
  import cart_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      item_valid,
  input  logic [ID_W-1:0]           item_id,
  input  logic [PRICE_W-1:0]        item_price,
  output logic                      item_ready,
  input  logic                      clear_cart,
  output logic [N_SLOTS*ID_W-1:0]   product_IDS,
  output logic [N_SLOTS*SLOT_W-1:0] numbers,
  output logic [TOTAL_W-1:0]        total_price,
  output logic                      cart_full,
  output logic                      err
);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q, hit_idx_q, free_idx_q, cand_idx_q;
  logic               hit_q, free_q, reject_q, err_q, full_q;
  logic [ID_W-1:0]    id_lat_q;
  logic [PRICE_W-1:0] price_lat_q;

  logic [ID_W-1:0]    id_q   [N_SLOTS];
  logic [QTY_W-1:0]   qty_q  [N_SLOTS];
  logic [PRICE_W-1:0] unit_q [N_SLOTS];
  logic [PRICE_W-1:0] line_q [N_SLOTS];
  logic [TOTAL_W-1:0] total_q;

  logic [QTY_W-1:0]   cand_qty_q;
  logic [PRICE_W-1:0] cand_unit_q, cand_line_q;
  logic [TOTAL_W-1:0] cand_total_q;

  logic [IDX_W-1:0]   sel_idx;
  logic [PRICE_W-1:0] addend_d, line_base_d, line_sum;
  logic [QTY_W-1:0]   qty_sum, qty_d;
  logic [TOTAL_W-1:0] total_sum;
  logic               qty_carry, line_carry, total_carry, reject_d, full_after;

  // A hit reuses the stored unit price; a miss takes the latched scan price.
  assign sel_idx     = hit_q ? hit_idx_q : free_idx_q;
  assign addend_d    = hit_q ? unit_q[sel_idx] : price_lat_q;
  assign line_base_d = hit_q ? line_q[sel_idx] : '0;
  assign qty_d       = hit_q ? qty_sum : {{(QTY_W-1){1'b0}}, 1'b1};
  assign reject_d    = (!hit_q && !free_q) || (hit_q && qty_carry) || line_carry || total_carry;

  bcd_adder #(.DIGITS(2)) u_qty_add (
    .a_i     (qty_q[hit_idx_q]),
    .b_i     ({{(QTY_W-1){1'b0}}, 1'b1}),
    .sum_o   (qty_sum),
    .carry_o (qty_carry)
  );

  bcd_adder #(.DIGITS(PRICE_DIGITS)) u_line_add (
    .a_i     (line_base_d),
    .b_i     (addend_d),
    .sum_o   (line_sum),
    .carry_o (line_carry)
  );

  bcd_adder #(.DIGITS(TOTAL_DIGITS)) u_total_add (
    .a_i     (total_q),
    .b_i     ({{(TOTAL_W-PRICE_W){1'b0}}, addend_d}),
    .sum_o   (total_sum),
    .carry_o (total_carry)
  );

  // The committed slot always gets a non-empty ID, so it counts as occupied.
  always_comb begin
    full_after = 1'b1;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (id_q[k] == EMPTY_ID && IDX_W'(k) != cand_idx_q) full_after = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      hit_idx_q    <= '0;
      free_idx_q   <= '0;
      cand_idx_q   <= '0;
      hit_q        <= 1'b0;
      free_q       <= 1'b0;
      reject_q     <= 1'b0;
      err_q        <= 1'b0;
      full_q       <= 1'b0;
      id_lat_q     <= EMPTY_ID;
      price_lat_q  <= '0;
      cand_qty_q   <= '0;
      cand_unit_q  <= '0;
      cand_line_q  <= '0;
      cand_total_q <= '0;
      total_q      <= '0;
      for (int k = 0; k < N_SLOTS; k++) begin
        id_q[k]   <= EMPTY_ID;
        qty_q[k]  <= '0;
        unit_q[k] <= '0;
        line_q[k] <= '0;
      end
    end else if (clear_cart) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      total_q <= '0;
      for (int k = 0; k < N_SLOTS; k++) begin
        id_q[k]   <= EMPTY_ID;
        qty_q[k]  <= '0;
        unit_q[k] <= '0;
        line_q[k] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          err_q <= 1'b0;
          if (item_valid) begin
            if (item_id == EMPTY_ID) begin
              err_q <= 1'b1;
            end else begin
              state_q     <= ST_SCAN;
              id_lat_q    <= item_id;
              price_lat_q <= item_price;
              idx_q       <= '0;
              hit_q       <= 1'b0;
              free_q      <= 1'b0;
            end
          end
        end
        ST_SCAN: begin
          if (!hit_q && id_q[idx_q] == id_lat_q) begin
            hit_q     <= 1'b1;
            hit_idx_q <= idx_q;
          end
          if (!free_q && id_q[idx_q] == EMPTY_ID) begin
            free_q     <= 1'b1;
            free_idx_q <= idx_q;
          end
          if (idx_q == IDX_W'(N_SLOTS-1)) state_q <= ST_CHECK;
          else                            idx_q   <= idx_q + IDX_W'(1);
        end
        ST_CHECK: begin
          cand_idx_q   <= sel_idx;
          cand_qty_q   <= qty_d;
          cand_unit_q  <= addend_d;
          cand_line_q  <= line_sum;
          cand_total_q <= total_sum;
          reject_q     <= reject_d;
          err_q        <= reject_d;
          state_q      <= ST_COMMIT;
        end
        ST_COMMIT: begin
          if (!reject_q) begin
            id_q[cand_idx_q]   <= id_lat_q;
            qty_q[cand_idx_q]  <= cand_qty_q;
            unit_q[cand_idx_q] <= cand_unit_q;
            line_q[cand_idx_q] <= cand_line_q;
            total_q            <= cand_total_q;
            full_q             <= full_after;
          end
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_SLOTS; k++) begin : g_out
    assign product_IDS[ID_W*k +: ID_W]                = id_q[k];
    assign numbers[SLOT_W*k + QTY_LSB  +: QTY_W]      = qty_q[k];
    assign numbers[SLOT_W*k + UNIT_LSB +: PRICE_W]    = unit_q[k];
    assign numbers[SLOT_W*k + LINE_LSB +: PRICE_W]    = line_q[k];
  end

  assign item_ready  = (state_q == ST_IDLE);
  assign total_price = total_q;
  assign cart_full   = full_q;
  assign err         = err_q;

endmodule

// File: tb/tb_cart_accumulator.sv
// Self-checking bench for cart_accumulator against a decimal-integer cart model.
module tb_cart_accumulator;
  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         item_valid;
  logic [7:0]   item_id;
  logic [15:0]  item_price;
  logic         item_ready;
  logic         clear_cart;
  logic [47:0]  product_IDS;
  logic [239:0] numbers;
  logic [19:0]  total_price;
  logic         cart_full;
  logic         err;
  logic [308:0] dut_vec;

  int checks = 0;
  int errors = 0;

  int m_id[6], m_qty[6], m_unit[6], m_line[6];
  int m_total;

  always #5 CLK = ~CLK;

  cart_accumulator dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .item_valid  (item_valid),
    .item_id     (item_id),
    .item_price  (item_price),
    .item_ready  (item_ready),
    .clear_cart  (clear_cart),
    .product_IDS (product_IDS),
    .numbers     (numbers),
    .total_price (total_price),
    .cart_full   (cart_full),
    .err         (err)
  );

  assign dut_vec = {product_IDS, numbers, total_price, cart_full};

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [308:0] exp_vec();
    logic [47:0]  ids;
    logic [239:0] nums;
    logic [19:0]  q, u, l, t;
    logic         full;
    full = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ids[8*k +: 8] = 8'(m_id[k]);
      q = to_bcd(m_qty[k]);
      u = to_bcd(m_unit[k]);
      l = to_bcd(m_line[k]);
      nums[40*k +: 40] = {q[7:0], u[15:0], l[15:0]};
      if (m_id[k] == 0) full = 1'b0;
    end
    t = to_bcd(m_total);
    return {ids, nums, t, full};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 6; k++) begin
      m_id[k] = 0; m_qty[k] = 0; m_unit[k] = 0; m_line[k] = 0;
    end
    m_total = 0;
  endtask

  task automatic model_scan(input int id, input int price, output bit rej);
    int hit, free;
    hit = -1;
    free = -1;
    for (int k = 0; k < 6; k++) begin
      if (hit < 0 && m_id[k] == id) hit = k;
      if (free < 0 && m_id[k] == 0) free = k;
    end
    rej = 1'b0;
    if (hit >= 0) begin
      if (m_qty[hit] == 99 || m_line[hit] + m_unit[hit] > 9999 || m_total + m_unit[hit] > 99999)
        rej = 1'b1;
      else begin
        m_qty[hit]++;
        m_line[hit] += m_unit[hit];
        m_total += m_unit[hit];
      end
    end else if (free < 0 || m_total + price > 99999) begin
      rej = 1'b1;
    end else begin
      m_id[free] = id; m_qty[free] = 1; m_unit[free] = price; m_line[free] = price;
      m_total += price;
    end
  endtask

  // Starts and ends on a falling edge; checks stall, err timing and frozen outputs.
  task automatic do_scan(input logic [7:0] id, input int price, input bit noisy);
    logic [308:0] pre, post;
    logic [19:0]  pb;
    bit           rej;
    int           n;
    n = 0;
    while (item_ready !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (item_ready !== 1'b1) begin
      errors++;
      $display("FAIL scan_ready_wait: item_ready=%b required 1", item_ready);
      return;
    end
    pre = exp_vec();
    model_scan(int'(id), price, rej);
    post = exp_vec();
    pb = to_bcd(price);
    item_valid = 1'b1;
    item_id    = id;
    item_price = pb[15:0];
    @(posedge CLK);
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      checks++;
      if ({item_ready, err} !== {1'b0, (c == 7) && rej}) begin
        errors++;
        $display("FAIL scan_busy id=%h cyc=%0d: ready,err=%b required %b", id, c, {item_ready, err}, {1'b0, (c == 7) && rej});
      end
      checks++;
      if (dut_vec !== pre) begin
        errors++;
        $display("FAIL scan_frozen id=%h cyc=%0d: got %h required %h", id, c, dut_vec, pre);
      end
      pb = to_bcd($urandom_range(0, 9999));
      item_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      item_id    = 8'($urandom_range(0, 255));
      item_price = pb[15:0];
    end
    @(negedge CLK);
    item_valid = 1'b0;
    checks++;
    if ({item_ready, err} !== 2'b10) begin
      errors++;
      $display("FAIL scan_done id=%h: ready,err=%b required 10", id, {item_ready, err});
    end
    checks++;
    if (dut_vec !== post) begin
      errors++;
      $display("FAIL scan_result id=%h: got %h required %h", id, dut_vec, post);
    end
  endtask

  task automatic do_clear();
    clear_cart = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    clear_cart = 1'b0;
    model_reset();
    checks++;
    if (dut_vec !== exp_vec() || {item_ready, err} !== 2'b10) begin
      errors++;
      $display("FAIL clear: outputs=%h ready,err=%b required zero and 10", dut_vec, {item_ready, err});
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (dut_vec !== '0 || {item_ready, err} !== 2'b10) begin
      errors++;
      $display("FAIL reset_held: outputs=%h ready,err=%b required zero and 10", dut_vec, {item_ready, err});
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (dut_vec !== '0 || {item_ready, err} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: outputs=%h ready,err=%b required zero and 10", dut_vec, {item_ready, err});
    end
  endtask

  task automatic test_first_scan();
    do_scan(8'h11, 250, 1'b0);
    checks++;
    if (product_IDS[7:0] !== 8'h11 || numbers[39:0] !== 40'h01_0250_0250 || total_price !== 20'h00250 || item_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_scan: id=%h slot=%h total=%h ready=%b required 11 0102500250 00250 1", product_IDS[7:0], numbers[39:0], total_price, item_ready);
    end
  endtask

  task automatic test_same_id();
    do_scan(8'h11, 999, 1'b0);
    checks++;
    if (numbers[39:0] !== 40'h02_0250_0500 || total_price !== 20'h00500) begin
      errors++;
      $display("FAIL same_id: slot=%h total=%h required 0202500500 00500", numbers[39:0], total_price);
    end
  endtask

  task automatic test_full_cart();
    do_clear();
    for (int i = 1; i <= 6; i++) do_scan(8'(i), 1, 1'b0);
    checks++;
    if (cart_full !== 1'b1 || total_price !== 20'h00006) begin
      errors++;
      $display("FAIL full_cart: cart_full=%b total=%h required 1 00006", cart_full, total_price);
    end
    do_scan(8'h07, 1, 1'b0);
    checks++;
    if (cart_full !== 1'b1 || total_price !== 20'h00006 || product_IDS !== 48'h06_05_04_03_02_01) begin
      errors++;
      $display("FAIL full_reject: cart_full=%b total=%h ids=%h required 1 00006 060504030201", cart_full, total_price, product_IDS);
    end
  endtask

  task automatic test_line_carry();
    do_clear();
    do_scan(8'h22, 5000, 1'b0);
    do_scan(8'h22, 5000, 1'b0);
    checks++;
    if (numbers[39:0] !== 40'h01_5000_5000 || total_price !== 20'h05000) begin
      errors++;
      $display("FAIL line_carry: slot=%h total=%h required 0150005000 05000", numbers[39:0], total_price);
    end
  endtask

  task automatic test_qty_limit();
    do_clear();
    for (int i = 0; i < 100; i++) do_scan(8'h33, 1, 1'b0);
    checks++;
    if (numbers[39:0] !== 40'h99_0001_0099 || total_price !== 20'h00099) begin
      errors++;
      $display("FAIL qty_limit: slot=%h total=%h required 9900010099 00099", numbers[39:0], total_price);
    end
  endtask

  task automatic test_clear();
    do_clear();
    do_scan(8'h41, 1234, 1'b0);
    do_scan(8'h42, 77, 1'b0);
    item_valid = 1'b1;
    item_id    = 8'h43;
    item_price = 16'h0500;
    @(posedge CLK);
    @(negedge CLK);
    item_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    clear_cart = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    clear_cart = 1'b0;
    model_reset();
    checks++;
    if (dut_vec !== exp_vec() || {item_ready, err} !== 2'b10) begin
      errors++;
      $display("FAIL clear_mid_scan: outputs=%h ready,err=%b required zero and 10", dut_vec, {item_ready, err});
    end
    @(negedge CLK);
    checks++;
    if ({item_ready, err} !== 2'b10) begin
      errors++;
      $display("FAIL clear_abort_err: ready,err=%b required 10", {item_ready, err});
    end
    item_valid = 1'b1;
    clear_cart = 1'b1;
    item_id    = 8'h44;
    item_price = 16'h0300;
    @(posedge CLK);
    @(negedge CLK);
    item_valid = 1'b0;
    clear_cart = 1'b0;
    checks++;
    if ({item_ready, err} !== 2'b10 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL clear_wins: ready,err=%b outputs=%h required 10 and zero", {item_ready, err}, dut_vec);
    end
    do_scan(8'h45, 300, 1'b0);
  endtask

  task automatic test_zero_id();
    logic [308:0] pre;
    pre = exp_vec();
    item_valid = 1'b1;
    item_id    = 8'h00;
    item_price = 16'h1234;
    @(posedge CLK);
    @(negedge CLK);
    item_valid = 1'b0;
    checks++;
    if ({item_ready, err} !== 2'b11 || dut_vec !== pre) begin
      errors++;
      $display("FAIL zero_id_pulse: ready,err=%b outputs=%h required 11 and %h", {item_ready, err}, dut_vec, pre);
    end
    @(negedge CLK);
    checks++;
    if ({item_ready, err} !== 2'b10) begin
      errors++;
      $display("FAIL zero_id_end: ready,err=%b required 10", {item_ready, err});
    end
    do_scan(8'h46, 15, 1'b0);
  endtask

  task automatic test_random();
    int price;
    do_clear();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 19) == 0) do_clear();
      if ($urandom_range(0, 9) < 7) price = $urandom_range(0, 999);
      else                          price = $urandom_range(3000, 9999);
      do_scan(8'($urandom_range(1, 8)), price, 1'b1);
    end
  endtask

  task automatic test_reset_mid_commit();
    do_scan(8'h55, 1234, 1'b0);
    item_valid = 1'b1;
    item_id    = 8'h56;
    item_price = 16'h0100;
    @(posedge CLK);
    @(negedge CLK);
    item_valid = 1'b0;
    repeat (7) @(posedge CLK);
    #2;
    checks++;
    if (item_ready !== 1'b0) begin
      errors++;
      $display("FAIL commit_busy: item_ready=%b required 0", item_ready);
    end
    RESET_N = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== '0 || {item_ready, err} !== 2'b10) begin
      errors++;
      $display("FAIL async_reset: outputs=%h ready,err=%b required zero and 10", dut_vec, {item_ready, err});
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    do_scan(8'h66, 42, 1'b0);
  endtask

  initial begin
    RESET_N    = 1'b0;
    item_valid = 1'b0;
    item_id    = 8'h00;
    item_price = 16'h0000;
    clear_cart = 1'b0;
    model_reset();
    test_reset();
    test_first_scan();
    test_same_id();
    test_full_cart();
    test_line_carry();
    test_qty_limit();
    test_clear();
    test_zero_id();
    test_random();
    test_reset_mid_commit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
